// File: rtl/counter_driver.sv
// Command sequencer for a chain of cascaded 4-bit synchronous counters: issues LOAD, COUNT and
// CLEAR strobes, tracks the value the chain should hold and flags any readback disagreement.
module counter_driver #(
  parameter int unsigned STAGES = 4,
  localparam int unsigned W = 4 * STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_data,
  output logic [W-1:0] P,
  output logic         load_n,
  output logic         clr_n,
  output logic         enp,
  output logic         ent,
  input  logic [W-1:0] Q,
  output logic         busy,
  output logic         done,
  output logic         mismatch
);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpCount = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StCount, StClear, StCheck} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] exp_q, exp_d;
  logic [W-1:0] p_q, p_d;
  logic         chk_q, chk_d;
  logic         mismatch_q, mismatch_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         load_n_q, load_n_d;
  logic         clr_n_q, clr_n_d;
  logic         en_q, en_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    p_d        = p_q;
    chk_d      = chk_q;
    mismatch_d = mismatch_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          chk_d = 1'b1;
          case (req_op)
            OpNop: begin
              chk_d   = 1'b0;
              state_d = StCheck;
            end
            OpLoad: begin
              p_d     = req_data;
              exp_d   = req_data;
              state_d = StLoad;
            end
            OpCount: begin
              cnt_d   = req_data;
              exp_d   = exp_q + req_data;
              state_d = (req_data == '0) ? StCheck : StCount;
            end
            OpClear: begin
              exp_d   = '0;
              state_d = StClear;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StLoad, StClear: state_d = StCheck;
      StCount: begin
        // One trailing cycle with enables low lets the last increment land before the check.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (chk_q && (Q != exp_q)) begin
          mismatch_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    ready_d  = (state_d == StIdle);
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StCheck);
    load_n_d = (state_d != StLoad);
    clr_n_d  = (state_d != StClear);
    en_d     = (state_d == StCount) && (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      exp_q      <= '0;
      p_q        <= '0;
      chk_q      <= 1'b0;
      mismatch_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_n_q   <= 1'b1;
      clr_n_q    <= 1'b1;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      p_q        <= p_d;
      chk_q      <= chk_d;
      mismatch_q <= mismatch_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_n_q   <= load_n_d;
      clr_n_q    <= clr_n_d;
      en_q       <= en_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign P         = p_q;
  assign load_n    = load_n_q;
  assign clr_n     = clr_n_q;
  assign enp       = en_q;
  assign ent       = en_q;

endmodule

// File: tb/tb_counter_driver.sv
// Directed bench for counter_driver with a behavioural model of the cascaded counter chain.
module tb_counter_driver;

  localparam int unsigned STAGES = 4;
  localparam int unsigned W = 4 * STAGES;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] P;
  logic         load_n, clr_n, enp, ent;
  logic [W-1:0] Q;
  logic         busy, done, mismatch;

  logic [W-1:0] q_model = '0;
  logic         q_force = 1'b0;
  logic [W-1:0] q_force_val = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt, done_cnt, done_at, ready_early;

  always #5 clk = ~clk;

  // Cascaded counters behave as one W-bit synchronous counter with sync clear and load.
  always @(posedge clk) begin
    if (!clr_n)            q_model <= '0;
    else if (!load_n)      q_model <= P;
    else if (enp && ent)   q_model <= q_model + 1'b1;
  end
  assign Q = q_force ? q_force_val : q_model;

  counter_driver #(.STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_data (req_data),
    .P        (P),
    .load_n   (load_n),
    .clr_n    (clr_n),
    .enp      (enp),
    .ent      (ent),
    .Q        (Q),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
  endtask

  initial begin
    // Reset, with a request presented that must be dropped
    #1 rst = 1'b1;
    issue(2'b01, 16'h5555);
    #1;
    check("rst_ready",   {31'd0, req_ready}, 32'd0);
    check("rst_busy",    {31'd0, busy},      32'd0);
    check("rst_done",    {31'd0, done},      32'd0);
    check("rst_mism",    {31'd0, mismatch},  32'd0);
    check("rst_load_n",  {31'd0, load_n},    32'd1);
    check("rst_clr_n",   {31'd0, clr_n},     32'd1);
    check("rst_en",      {30'd0, enp, ent},  32'd0);
    check("rst_P",       {16'd0, P},         32'd0);
    step();
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    step();
    check("rel_ready",   {31'd0, req_ready}, 32'd1);
    check("rel_busy",    {31'd0, busy},      32'd0);
    check("rel_load_n",  {31'd0, load_n},    32'd1);

    // LOAD 0x1234
    issue(2'b01, 16'h1234);
    step();
    req_valid = 1'b0;
    check("ld_load_n",   {31'd0, load_n},    32'd0);
    check("ld_P",        {16'd0, P},         32'h1234);
    check("ld_busy",     {30'd0, busy, req_ready}, 32'd2);
    check("ld_done1",    {31'd0, done},      32'd0);
    check("ld_other",    {29'd0, clr_n, enp, ent}, 32'd4);
    step();
    check("ld_done2",    {31'd0, done},      32'd1);
    check("ld_load_n2",  {31'd0, load_n},    32'd1);
    check("ld_Q",        {16'd0, Q},         32'h1234);
    step();
    check("ld_idle",     {29'd0, done, busy, req_ready}, 32'd1);
    check("ld_mism",     {31'd0, mismatch},  32'd0);

    // LOAD 0xFFFE then COUNT 3 (wraps to 0x0001)
    issue(2'b01, 16'hFFFE);
    step();
    req_valid = 1'b0;
    step();
    step();
    issue(2'b10, 16'd3);
    en_cnt = 0;
    done_at = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      req_valid = 1'b0;
      if (enp && ent) en_cnt++;
      if (done) done_at = c;
      if (c == 4) check("cnt3_en_c4", {30'd0, enp, ent}, 32'd0);
    end
    check("cnt3_en_cycles", en_cnt, 32'd3);
    check("cnt3_done_at",   done_at, 32'd5);
    check("cnt3_Q",         {16'd0, Q}, 32'h0001);
    check("cnt3_mism",      {31'd0, mismatch}, 32'd0);
    check("cnt3_ready",     {31'd0, req_ready}, 32'd1);

    // COUNT 0
    issue(2'b10, 16'd0);
    step();
    req_valid = 1'b0;
    check("cnt0_done",   {31'd0, done},      32'd1);
    check("cnt0_en",     {30'd0, enp, ent},  32'd0);
    check("cnt0_ready1", {31'd0, req_ready}, 32'd0);
    step();
    check("cnt0_ready2", {30'd0, req_ready, done}, 32'd2);
    check("cnt0_mism",   {31'd0, mismatch},  32'd0);

    // LOAD 0x00FF with a wrong readback, then a correct CLEAR
    issue(2'b01, 16'h00FF);
    step();
    req_valid = 1'b0;
    q_force = 1'b1;
    q_force_val = 16'h00FE;
    step();
    check("bad_done",    {31'd0, done},      32'd1);
    step();
    q_force = 1'b0;
    check("bad_mism",    {31'd0, mismatch},  32'd1);
    issue(2'b11, 16'hABCD);
    step();
    req_valid = 1'b0;
    check("clr_clr_n",   {31'd0, clr_n},     32'd0);
    check("clr_others",  {29'd0, load_n, enp, ent}, 32'd4);
    step();
    check("clr_done",    {31'd0, done},      32'd1);
    check("clr_Q",       {16'd0, Q},         32'd0);
    step();
    check("clr_mism_sticky", {31'd0, mismatch}, 32'd1);

    // Reset two cycles into COUNT 10
    issue(2'b10, 16'd10);
    step();
    req_valid = 1'b0;
    check("abort_en1",   {30'd0, enp, ent},  32'd3);
    step();
    check("abort_en2",   {30'd0, enp, ent},  32'd3);
    rst = 1'b1;
    #1;
    check("abort_en_now", {30'd0, enp, ent}, 32'd0);
    check("abort_state", {28'd0, busy, done, req_ready, mismatch}, 32'd0);
    step();
    check("abort_done",  {31'd0, done},      32'd0);
    rst = 1'b0;
    step();
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (done || busy || enp) done_cnt++;
      step();
    end
    check("abort_quiet", done_cnt, 32'd0);

    // CLEAR to sync the chain, then COUNT 4 with req_valid held through busy
    issue(2'b11, 16'd0);
    step();
    req_valid = 1'b0;
    step();
    step();
    issue(2'b10, 16'd4);
    en_cnt = 0;
    done_cnt = 0;
    ready_early = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (enp && ent) en_cnt++;
      if (done) done_cnt++;
      if (c < 7 && req_ready) ready_early++;
      if (c == 7) check("hold_ready_c7", {31'd0, req_ready}, 32'd1);
      req_data = (c == 7) ? 16'd2 : (16'h0F00 + 16'(c));
    end
    check("hold_en_cycles", en_cnt, 32'd4);
    check("hold_done_cnt",  done_cnt, 32'd1);
    check("hold_ready_busy", ready_early, 32'd0);
    step();
    req_valid = 1'b0;
    check("hold_next_acc", {30'd0, busy, enp}, 32'd3);
    en_cnt = 0;
    done_at = 0;
    for (int c = 9; c <= 12; c++) begin
      step();
      if (enp && ent) en_cnt++;
      if (done) done_at = c;
    end
    check("hold2_en",      en_cnt, 32'd1);
    check("hold2_done_at", done_at, 32'd11);
    check("hold2_Q",       {16'd0, Q}, 32'h0006);
    check("hold2_mism",    {31'd0, mismatch}, 32'd0);

    // NOP never checks, even with a wrong readback
    issue(2'b00, 16'h7777);
    q_force = 1'b1;
    q_force_val = 16'hBEEF;
    step();
    req_valid = 1'b0;
    check("nop_c1", {27'd0, done, busy, load_n, clr_n, enp}, 32'h1E);
    step();
    q_force = 1'b0;
    check("nop_c2", {29'd0, done, busy, req_ready}, 32'd1);
    check("nop_mism", {31'd0, mismatch}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
